// File: rtl/imem_loader_if.sv
// Byte-stream and SRAM write-port signals shared by the instruction memory loader.
// The master side drives the byte stream; the slave side (the loader) drives the SRAM port.
interface imem_loader_if #(
    parameter int unsigned ADDR_WIDTH = 11
);
    logic [7:0]            rx_data;
    logic                  rx_valid;
    logic                  rx_ready;
    logic [ADDR_WIDTH-1:0] mem_a;
    logic [31:0]           mem_d;
    logic                  mem_cen;
    logic                  mem_wen;

    modport master (
        output rx_data,
        output rx_valid,
        input  rx_ready,
        input  mem_a,
        input  mem_d,
        input  mem_cen,
        input  mem_wen
    );

    modport slave (
        input  rx_data,
        input  rx_valid,
        output rx_ready,
        output mem_a,
        output mem_d,
        output mem_cen,
        output mem_wen
    );
endinterface

// File: rtl/imem_loader.sv
// Boot loader: parses a length/data/checksum byte frame and writes little-endian words
// into the instruction SRAM, holding the core in reset until a load succeeds.
module imem_loader #(
    parameter int unsigned ADDR_WIDTH = 11,
    parameter int unsigned MAX_WORDS  = 2048
) (
    input  logic                i_clk,
    input  logic                i_rst,
    input  logic                i_start,
    imem_loader_if.slave        io_bus,
    output logic                o_core_hold,
    output logic                o_busy,
    output logic                o_done,
    output logic                o_err,
    output logic [ADDR_WIDTH:0] o_words_loaded
);
    localparam int unsigned LEN_W = 16;
    localparam int unsigned CNT_W = ADDR_WIDTH + 1;

    typedef enum logic [2:0] {
        S_IDLE,
        S_LEN0,
        S_LEN1,
        S_DATA,
        S_WRITE,
        S_CSUM,
        S_OK,
        S_FAIL
    } state_t;

    state_t                r_state;
    state_t                w_state_nxt;

    logic                  r_rx_ready;
    logic                  r_busy;
    logic                  r_mem_cen;
    logic                  r_mem_wen;
    logic [ADDR_WIDTH-1:0] r_mem_a;
    logic [31:0]           r_mem_d;
    logic                  r_done;
    logic                  r_err;
    logic                  r_hold;
    logic [7:0]            r_len_lo;
    logic [LEN_W-1:0]      r_len;
    logic [CNT_W-1:0]      r_idx;
    logic [1:0]            r_byte_cnt;
    logic [23:0]           r_word;
    logic [7:0]            r_csum;

    logic                  w_rx_fire;
    logic [LEN_W-1:0]      w_len_full;
    logic                  w_len_bad;
    logic                  w_len_zero;
    logic [CNT_W-1:0]      w_idx_inc;
    logic                  w_last_word;
    logic                  w_csum_ok;

    assign w_rx_fire   = io_bus.rx_valid && r_rx_ready;
    assign w_len_full  = {io_bus.rx_data, r_len_lo};
    assign w_len_bad   = w_len_full > LEN_W'(MAX_WORDS);
    assign w_len_zero  = w_len_full == '0;
    assign w_idx_inc   = r_idx + CNT_W'(1);
    assign w_last_word = LEN_W'(w_idx_inc) == r_len;
    assign w_csum_ok   = io_bus.rx_data == r_csum;

    // State register
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Next-state decode
    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_IDLE:  if (i_start) w_state_nxt = S_LEN0;
            S_LEN0:  if (w_rx_fire) w_state_nxt = S_LEN1;
            S_LEN1: begin
                if (w_rx_fire) begin
                    if (w_len_bad)       w_state_nxt = S_FAIL;
                    else if (w_len_zero) w_state_nxt = S_CSUM;
                    else                 w_state_nxt = S_DATA;
                end
            end
            S_DATA:  if (w_rx_fire && (r_byte_cnt == 2'd3)) w_state_nxt = S_WRITE;
            S_WRITE: w_state_nxt = w_last_word ? S_CSUM : S_DATA;
            S_CSUM:  if (w_rx_fire) w_state_nxt = w_csum_ok ? S_OK : S_FAIL;
            S_OK:    w_state_nxt = S_IDLE;
            S_FAIL:  w_state_nxt = S_IDLE;
            default: w_state_nxt = S_IDLE;
        endcase
    end

    // Handshake and strobe outputs registered from the next state so they align with it
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_rx_ready <= 1'b0;
            r_busy     <= 1'b0;
            r_mem_cen  <= 1'b1;
            r_mem_wen  <= 1'b1;
        end else begin
            r_rx_ready <= w_state_nxt inside {S_LEN0, S_LEN1, S_DATA, S_CSUM};
            r_busy     <= w_state_nxt != S_IDLE;
            r_mem_cen  <= w_state_nxt != S_WRITE;
            r_mem_wen  <= w_state_nxt != S_WRITE;
        end
    end

    // Frame datapath: length capture, word assembly, checksum and sticky status
    always_ff @(posedge i_clk or posedge i_rst) begin
        if (i_rst) begin
            r_mem_a    <= '0;
            r_mem_d    <= '0;
            r_done     <= 1'b0;
            r_err      <= 1'b0;
            r_hold     <= 1'b1;
            r_len_lo   <= '0;
            r_len      <= '0;
            r_idx      <= '0;
            r_byte_cnt <= '0;
            r_word     <= '0;
            r_csum     <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_start) begin
                        r_done     <= 1'b0;
                        r_err      <= 1'b0;
                        r_hold     <= 1'b1;
                        r_idx      <= '0;
                        r_csum     <= '0;
                        r_byte_cnt <= '0;
                    end
                end
                S_LEN0: begin
                    if (w_rx_fire) begin
                        r_len_lo <= io_bus.rx_data;
                        r_csum   <= r_csum + io_bus.rx_data;
                    end
                end
                S_LEN1: begin
                    if (w_rx_fire) begin
                        r_len  <= w_len_full;
                        r_csum <= r_csum + io_bus.rx_data;
                        if (w_len_bad) r_err <= 1'b1;
                    end
                end
                S_DATA: begin
                    if (w_rx_fire) begin
                        r_csum     <= r_csum + io_bus.rx_data;
                        r_byte_cnt <= r_byte_cnt + 2'd1;
                        // Bytes shift in from the top so lane 0 ends up least significant
                        r_word     <= {io_bus.rx_data, r_word[23:8]};
                        if (r_byte_cnt == 2'd3) begin
                            r_mem_a <= r_idx[ADDR_WIDTH-1:0];
                            r_mem_d <= {io_bus.rx_data, r_word};
                        end
                    end
                end
                S_WRITE: r_idx <= w_idx_inc;
                S_CSUM: begin
                    if (w_rx_fire) begin
                        if (w_csum_ok) begin
                            r_done <= 1'b1;
                            r_hold <= 1'b0;
                        end else begin
                            r_err <= 1'b1;
                        end
                    end
                end
                default: ;
            endcase
        end
    end

    assign io_bus.rx_ready = r_rx_ready;
    assign io_bus.mem_a    = r_mem_a;
    assign io_bus.mem_d    = r_mem_d;
    assign io_bus.mem_cen  = r_mem_cen;
    assign io_bus.mem_wen  = r_mem_wen;
    assign o_core_hold     = r_hold;
    assign o_busy          = r_busy;
    assign o_done          = r_done;
    assign o_err           = r_err;
    assign o_words_loaded  = r_idx;
endmodule

// File: doc/imem_loader.md
# imem_loader

Boot-time program loader that writes the instruction SRAM (XSPRAMLP_2048X32_M8P) from a byte stream. It is the writer side of the instruction memory that the pipeline fetch stage reads. It takes framed bytes from an upstream byte source (UART receiver) over a valid/ready handshake and assembles little-endian 32-bit words. It writes each word to consecutive SRAM word addresses, verifies a checksum, and holds the core in reset until a load completes successfully.

## Interface
- ADDR_WIDTH, 11, SRAM word-address width
- MAX_WORDS, 2048, largest accepted word count
- CLK  in  1  clock, rising edge
- RST  in  1  asynchronous, active-high reset
- START  in  1  single-cycle request to begin a load; ignored while BUSY
- RX_DATA  in  8  stream byte
- RX_VALID  in  1  RX_DATA valid
- RX_READY  out  1  loader accepts a byte this cycle
- MEM_A  out  ADDR_WIDTH  SRAM word address
- MEM_D  out  32  SRAM write data
- MEM_CEN  out  1  SRAM chip enable, active low
- MEM_WEN  out  1  SRAM write enable, active low
- CORE_HOLD  out  1  high keeps the pipeline in reset
- BUSY  out  1  load in progress
- DONE  out  1  sticky; last load succeeded
- ERR  out  1  sticky; last load failed
- WORDS_LOADED  out  ADDR_WIDTH+1  words written in the current or last load

## Operation
- Frame format: LEN_LO, LEN_HI (16-bit word count N), then 4·N data bytes with the LSB first in each word, then CSUM.
- CSUM must equal the 8-bit sum, mod 256, of all preceding frame bytes (length and data bytes).
- A byte transfer happens on a rising edge with RX_VALID && RX_READY. RX_DATA is ignored otherwise.
- States:
  - IDLE: waits for START; START → LEN0.
  - LEN0: accept LEN_LO → LEN1.
  - LEN1: accept LEN_HI. If N > MAX_WORDS → FAIL. If N = 0 → CSUM. Otherwise → DATA.
  - DATA: accept a byte into lane byte_cnt (0..3). After lane 3 → WRITE.
  - WRITE: one write cycle with MEM_CEN=0, MEM_WEN=0, MEM_A=word index, MEM_D=assembled word. Then index++ and WORDS_LOADED++. Go to CSUM if index = N, else DATA.
  - CSUM: accept CSUM byte. Match → OK; mismatch → FAIL.
  - OK: DONE=1, CORE_HOLD=0 → IDLE.
  - FAIL: ERR=1, CORE_HOLD stays 1 → IDLE.
- RX_READY=1 only in LEN0, LEN1, DATA and CSUM. It is 0 in IDLE, WRITE, OK and FAIL.
- BUSY=1 in every state except IDLE.
- START accepted in IDLE:
  - Clears DONE, ERR, WORDS_LOADED, the checksum accumulator and the word index.
  - Sets CORE_HOLD=1.
- Outside WRITE: MEM_CEN=1, MEM_WEN=1, and MEM_A/MEM_D hold their last values.
- Words already written before a FAIL remain in SRAM. No rollback.
- Checksum and counters wrap at their own widths. The N ≤ MAX_WORDS check guarantees the word index never wraps.

## Timing
- Reset values:
  - State IDLE.
  - RX_READY=0, MEM_A=0, MEM_D=0, MEM_CEN=1, MEM_WEN=1.
  - CORE_HOLD=1, BUSY=0, DONE=0, ERR=0, WORDS_LOADED=0.
- START sampled at edge k: BUSY=1 and RX_READY=1 during cycle k+1.
- All outputs are decoded from registered state and data registers. There is no combinational path from RX_VALID or RX_DATA to any output.
- Per word: at least 4 accept cycles plus 1 WRITE cycle, so 5 cycles per word with RX_VALID held high.
- The SRAM captures the write on the edge that ends the WRITE cycle.
- CSUM accepted at edge m: DONE or ERR is high and CORE_HOLD is updated in cycle m+1. BUSY falls in cycle m+2.
- Bad length accepted at edge m: ERR=1 in cycle m+1. No WRITE cycle occurs.
- START while BUSY: ignored, no effect.
- RST asserted mid-load:
  - Immediate abort; all outputs return to reset values asynchronously.
  - SRAM contents are left unchanged.
  - A new START is required.
- RX_VALID deasserting between bytes only stalls the FSM. Stalls have no timeout.

## Test plan
- Reset: assert RST mid-cycle → all outputs at reset values immediately. CORE_HOLD=1, MEM_WEN=1.
- Good 2-word load: START, then bytes 02 00 78 56 34 12 EF BE AD DE 4E.
  - Writes: A=0 D=0x12345678, then A=1 D=0xDEADBEEF, exactly 2 WRITE cycles.
  - Then DONE=1, ERR=0, CORE_HOLD=0, WORDS_LOADED=2.
- Bad checksum: the same frame with CSUM 4F → both words still written, then ERR=1, DONE=0, CORE_HOLD=1.
- Oversize and empty frames:
  - LEN bytes 01 08 (N=2049) → ERR=1 one cycle after LEN_HI, zero WRITE cycles.
  - Frame 00 00 00 → DONE=1, zero writes, WORDS_LOADED=0.
- Backpressure and gaps: random RX_VALID gaps plus a byte presented during WRITE.
  - RX_READY=0 in WRITE, and that byte is accepted the next cycle.
  - No byte is lost or duplicated; the SRAM image matches the golden model.
- Abort and restart: RST after the first word is written, then a full good frame → loads from A=0, DONE=1. A START pulsed mid-load has no effect.
